// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Iteration counter and working registers.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;       // latched divisor
  // The partial remainder is always strictly below the divisor after a step,
  // so only WIDTH bits need storing; the trial subtraction is WIDTH+1 bits wide.
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;     // latched divisor==0 flag

  // Result registers that hold until the next result write.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ov_q, ov_d;

  // Datapath for a single restoring step.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic             last_step;

  // One restoring step: shift next dividend bit into the remainder and trial-subtract.
  always_comb begin
    trial     = {r_q, q_q[WIDTH-1]};
    diff      = trial - {1'b0, d_q};
    qbit      = ~diff[WIDTH];
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and register-update logic; out_valid is a pulse, so it defaults low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ov_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          dz_d    = (divisor == '0);
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Restore on a negative trial difference by keeping the shifted value.
        r_d   = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          quo_d   = q_d;
          rem_d   = r_d;
          dbz_d   = dz_q;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    in_ready    = (state_q == IDLE);
    busy        = (state_q == BUSY);
    out_valid   = ov_q;
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule
